// File: rtl/ysyx_22050039_lsu_pkg.sv
// Shared LSU definitions: op field layout, size codes, illegal-op predicate, FSM encoding.
package ysyx_22050039_lsu_pkg;

  localparam int OP_STORE_BIT = 3;
  localparam int OP_UNS_BIT   = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Stores have no signedness, and a 64-bit load has nothing to extend.
  function automatic logic op_illegal(input logic [3:0] op);
    return op[OP_UNS_BIT] && (op[OP_STORE_BIT] || (op[1:0] == SZ_D));
  endfunction

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// Byte-lane alignment for the 8-byte bus: store mask/data shift, load extract + extend.
// Purely combinational; misalign flags accesses not naturally aligned to their size.
module ysyx_22050039_lsu_align
  import ysyx_22050039_lsu_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [5:0]  sh_bits;
  logic [63:0] rsh;
  logic [7:0]  base_mask;

  always_comb begin
    sh_bits   = {addr_lo, 3'b000};
    rsh       = rdata >> sh_bits;
    base_mask = 8'h01;
    misalign  = 1'b0;
    rdata_ext = 64'd0;
    case (size)
      SZ_B: begin
        base_mask = 8'h01;
        misalign  = 1'b0;
        rdata_ext = is_unsigned ? {56'd0, rsh[7:0]} : {{56{rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        base_mask = 8'h03;
        misalign  = addr_lo[0];
        rdata_ext = is_unsigned ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      end
      SZ_W: begin
        base_mask = 8'h0F;
        misalign  = |addr_lo[1:0];
        rdata_ext = is_unsigned ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      end
      default: begin
        base_mask = 8'hFF;
        misalign  = |addr_lo;
        rdata_ext = rsh;
      end
    endcase
    wmask    = base_mask << addr_lo;
    wdata_sh = wdata << sh_bits;
  end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: one op in flight, IDLE->REQ->WAIT->RESP, zero-wait load reaches RESP 3 cycles after accept.
// Request held until mem_req_ready; result held until out_ready; faults skip the bus.
module ysyx_22050039_lsu
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_base,
  input  logic [XLEN-1:0] in_offset,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_fault
);

  logic [1:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_fault_q, out_fault_d;

  logic [XLEN-1:0] acc_addr;
  logic            accept;
  logic [2:0]      al_addr;
  logic [3:0]      al_op;
  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misalign;

  assign acc_addr = in_base + in_offset;
  assign in_ready = (state_q == ST_IDLE) && rst;
  assign accept   = in_valid && in_ready;

  // The aligner sees the incoming op while idle (fault check) and the latched op otherwise.
  assign al_addr = (state_q == ST_IDLE) ? acc_addr[2:0] : addr_q[2:0];
  assign al_op   = (state_q == ST_IDLE) ? in_op : op_q;

  ysyx_22050039_lsu_align u_align (
    .addr_lo     (al_addr),
    .size        (al_op[1:0]),
    .is_unsigned (al_op[OP_UNS_BIT]),
    .wdata       (wdata_q),
    .rdata       (mem_rsp_data),
    .wmask       (al_wmask),
    .wdata_sh    (al_wdata),
    .rdata_ext   (al_rdata),
    .misalign    (al_misalign)
  );

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign mem_req_wen   = mem_req_valid && op_q[OP_STORE_BIT];
  assign mem_req_wmask = mem_req_valid ? al_wmask : 8'd0;
  assign mem_req_wdata = mem_req_valid ? al_wdata : '0;
  assign out_valid     = (state_q == ST_RESP);
  assign out_data      = out_data_q;
  assign out_rd        = rd_q;
  assign out_fault     = out_fault_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_data_d  = out_data_q;
    out_fault_d = out_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = in_op;
          rd_d       = in_rd;
          wdata_d    = in_wdata;
          addr_d     = acc_addr;
          out_data_d = '0;
          if (al_misalign || op_illegal(in_op)) begin
            out_fault_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            out_fault_d = 1'b0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = op_q[OP_STORE_BIT] ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          out_data_d = al_rdata;
          state_d    = ST_RESP;
        end
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for the LSU: loads, stores, faults, stalls and mid-op reset.
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_base, in_offset, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid, out_ready, out_fault;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  int errs   = 0;
  int checks = 0;
  int req_hs = 0;
  int out_hs = 0;

  always #5 clk = ~clk;

  ysyx_22050039_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_base       (in_base),
    .in_offset     (in_offset),
    .in_wdata      (in_wdata),
    .in_rd         (in_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_rd        (out_rd),
    .out_fault     (out_fault)
  );

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;
    if (out_valid && out_ready) out_hs <= out_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] base,
                        input logic [63:0] off, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rsp, input int req_stall, input int out_stall,
                        input bit exp_bus, input logic [63:0] e_addr, input logic [7:0] e_mask,
                        input logic [63:0] e_wdata, input logic [63:0] e_data,
                        input bit e_fault, input int e_lat);
    int cyc = 0;
    int rq0 = req_hs;
    int rs0 = out_hs;
    in_valid = 1'b1; in_op = op; in_base = base; in_offset = off; in_wdata = wd; in_rd = rd;
    mem_req_ready = 1'b0; out_ready = 1'b0;
    check({name, "_in_ready"}, in_ready, 1);
    @(negedge clk); cyc = 1;
    in_valid = 1'b0; in_op = 4'($urandom); in_base = {$urandom, $urandom};
    in_offset = {$urandom, $urandom}; in_wdata = {$urandom, $urandom}; in_rd = 5'($urandom);
    if (exp_bus) begin
      for (int i = 0; i <= req_stall; i++) begin
        if (i == req_stall) mem_req_ready = 1'b1;
        check({name, "_req_valid"}, mem_req_valid, 1);
        check({name, "_req_addr"}, mem_req_addr, e_addr);
        check({name, "_req_wen"}, mem_req_wen, op[3]);
        check({name, "_req_wmask"}, mem_req_wmask, e_mask);
        check({name, "_req_wdata"}, mem_req_wdata, e_wdata);
        @(negedge clk); cyc++;
      end
      mem_req_ready = 1'b0;
      if (!op[3]) begin
        check({name, "_wait_req"}, mem_req_valid, 0);
        check({name, "_wait_out"}, out_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
        @(negedge clk); cyc++;
        mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom};
      end
    end else begin
      check({name, "_no_req"}, mem_req_valid, 0);
    end
    if (e_lat >= 0) check({name, "_latency"}, cyc, e_lat);
    for (int i = 0; i <= out_stall; i++) begin
      if (i == out_stall) out_ready = 1'b1;
      check({name, "_out_valid"}, out_valid, 1);
      check({name, "_out_data"}, out_data, e_data);
      check({name, "_out_rd"}, out_rd, rd);
      check({name, "_out_fault"}, out_fault, e_fault);
      check({name, "_resp_req"}, mem_req_valid, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({name, "_out_drop"}, out_valid, 0);
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_req_hs"}, req_hs - rq0, exp_bus ? 1 : 0);
    check({name, "_out_hs"}, out_hs - rs0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_base = '0; in_offset = '0; in_wdata = '0;
    in_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_wmask", mem_req_wmask, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_fault", out_fault, 0);
    check("rst_out_rd", out_rd, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op("ld",  4'b0011, 64'h80000000, 64'h10, 64'h0, 5'd1, 64'h1122334455667788, 0, 0,
           1, 64'h80000010, 8'hFF, 64'h0, 64'h1122334455667788, 0, 3);
    run_op("lb",  4'b0000, 64'h80000000, 64'h3, 64'h0, 5'd2, 64'h0000000080FFFFFF, 0, 0,
           1, 64'h80000000, 8'h08, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 3);
    run_op("lbu", 4'b0100, 64'h80000000, 64'h3, 64'h0, 5'd3, 64'h0000000080FFFFFF, 0, 0,
           1, 64'h80000000, 8'h08, 64'h0, 64'h0000000000000080, 0, 3);
    run_op("sh",  4'b1001, 64'h80000000, 64'h6, 64'hABCD, 5'd4, 64'h0, 0, 0,
           1, 64'h80000000, 8'hC0, 64'hABCD000000000000, 64'h0, 0, 2);
    run_op("lw_mis", 4'b0010, 64'h80000000, 64'h2, 64'h0, 5'd5, 64'h0, 0, 0,
           0, 64'h0, 8'h0, 64'h0, 64'h0, 1, 1);
    run_op("ldu", 4'b0111, 64'h80000000, 64'h0, 64'h0, 5'd6, 64'h0, 0, 0,
           0, 64'h0, 8'h0, 64'h0, 64'h0, 1, 1);
    run_op("su",  4'b1100, 64'h80000000, 64'h0, 64'h55, 5'd7, 64'h0, 0, 0,
           0, 64'h0, 8'h0, 64'h0, 64'h0, 1, 1);
    run_op("lw_stall", 4'b0010, 64'h80000000, 64'h4, 64'h0, 5'd8, 64'hDEADBEEF12345678, 3, 2,
           1, 64'h80000000, 8'hF0, 64'h0, 64'hFFFFFFFFDEADBEEF, 0, -1);
    run_op("lhu", 4'b0101, 64'h80000000, 64'h6, 64'h0, 5'd9, 64'h8001000000000000, 0, 0,
           1, 64'h80000000, 8'hC0, 64'h0, 64'h0000000000008001, 0, 3);
    run_op("lh",  4'b0001, 64'h80000000, 64'h6, 64'h0, 5'd10, 64'h8001000000000000, 0, 0,
           1, 64'h80000000, 8'hC0, 64'h0, 64'hFFFFFFFFFFFF8001, 0, 3);
    run_op("sd_wrap", 4'b1011, 64'hFFFFFFFFFFFFFFF8, 64'h18, 64'h0123456789ABCDEF, 5'd11, 64'h0, 0, 0,
           1, 64'h10, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 0, 2);
    run_op("sb",  4'b1000, 64'h80000000, 64'h5, 64'h1234, 5'd12, 64'h0, 0, 0,
           1, 64'h80000000, 8'h20, 64'h0012340000000000, 64'h0, 0, 2);

    // Abandon a load while it waits for data.
    in_valid = 1'b1; in_op = 4'b0011; in_base = 64'h80000100; in_offset = 64'h0; in_rd = 5'd13;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("mid_wait_req", mem_req_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_req_valid", mem_req_valid, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_rd", out_rd, 0);
    check("mid_rst_req_addr", mem_req_addr, 0);
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hCAFEF00DCAFEF00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("late_rsp_out_valid", out_valid, 0);
    check("late_rsp_in_ready", in_ready, 1);
    check("late_rsp_out_data", out_data, 0);
    run_op("ld_after_rst", 4'b0011, 64'h80000000, 64'h20, 64'h0, 5'd14, 64'hA5A5A5A55A5A5A5A, 0, 0,
           1, 64'h80000020, 8'hFF, 64'h0, 64'hA5A5A5A55A5A5A5A, 0, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
